// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants and types for the data-memory responder:
//               MMIO register addresses, STATUS bit positions and the
//               address-region decode enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    // MMIO register byte addresses
    localparam logic [31:0] c_addr_txdata = 32'hFFFF_0000;
    localparam logic [31:0] c_addr_status = 32'hFFFF_0004;
    localparam logic [31:0] c_addr_errcnt = 32'hFFFF_0008;
    localparam logic [31:0] c_addr_rdcnt  = 32'hFFFF_000C;
    localparam logic [31:0] c_addr_wrcnt  = 32'hFFFF_0010;

    // STATUS register layout
    localparam int c_stat_full_bit  = 0;
    localparam int c_stat_empty_bit = 1;
    localparam int c_stat_ovf_bit   = 2;
    localparam int c_stat_cnt_lsb   = 4;
    localparam int c_stat_cnt_w     = 4;

    // Width of the saturating out-of-map access counter
    localparam int c_errcnt_w = 16;

    // Result of decoding a processor address
    typedef enum logic [2:0] {
        REGION_RAM    = 3'd0,
        REGION_TXDATA = 3'd1,
        REGION_STATUS = 3'd2,
        REGION_ERRCNT = 3'd3,
        REGION_RDCNT  = 3'd4,
        REGION_WRCNT  = 3'd5,
        REGION_NONE   = 3'd6
    } region_e;

    // Assemble the 8 significant bits of the STATUS register
    function automatic logic [7:0] pack_status(
        input logic                    full,
        input logic                    empty,
        input logic                    ovf,
        input logic [c_stat_cnt_w-1:0] count
    );
        logic [7:0] v;
        v = 8'h00;
        v[c_stat_full_bit]  = full;
        v[c_stat_empty_bit] = empty;
        v[c_stat_ovf_bit]   = ovf;
        v[c_stat_cnt_lsb +: c_stat_cnt_w] = count;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_tx_fifo.sv
// ============================================================================
// Module      : dmem_tx_fifo
// Description : Byte-wide transmit FIFO with push/pop, full/empty flags,
//               occupancy count and a sticky overflow flag. A push into a
//               full FIFO is still accepted when a pop happens in the same
//               cycle. Reset (active-low, asynchronous) empties the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_tx_fifo
    import dmem_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic [7:0]              i_push_data,
    input  logic                    i_pop_ready,
    input  logic                    i_ovf_clear,
    output logic [7:0]              o_data,
    output logic                    o_valid,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [c_stat_cnt_w-1:0] o_count,
    output logic                    o_overflow
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0]           c_last_ptr = PW'(FIFO_DEPTH - 1);
    localparam logic [c_stat_cnt_w-1:0] c_depth    = c_stat_cnt_w'(FIFO_DEPTH);

    logic [7:0]              r_mem [FIFO_DEPTH];
    logic [PW-1:0]           r_wptr;
    logic [PW-1:0]           r_rptr;
    logic [c_stat_cnt_w-1:0] r_count;
    logic                    r_ovf;

    logic                    w_valid;
    logic                    w_pop;
    logic                    w_push_ok;
    logic                    w_drop;
    logic [PW-1:0]           w_wptr_nxt;
    logic [PW-1:0]           w_rptr_nxt;

    // Handshake and acceptance: a pop frees a slot for a same-cycle push
    always_comb begin
        w_valid    = (r_count != '0);
        w_pop      = w_valid & i_pop_ready;
        w_push_ok  = i_push & ((r_count < c_depth) | w_pop);
        w_drop     = i_push & ~w_push_ok;
        w_wptr_nxt = (r_wptr == c_last_ptr) ? '0 : r_wptr + PW'(1);
        w_rptr_nxt = (r_rptr == c_last_ptr) ? '0 : r_rptr + PW'(1);
    end

    // Pointers, occupancy and sticky overflow; a drop wins over a clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_stat_cnt_w'(1);
                2'b01:   r_count <= r_count - c_stat_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clear) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Byte storage; contents become meaningless once the count is reset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // Head byte is forced to zero while empty so reset shows 0 at once
    always_comb begin
        o_data     = w_valid ? r_mem[r_rptr] : 8'h00;
        o_valid    = w_valid;
        o_full     = (r_count == c_depth);
        o_empty    = (r_count == '0);
        o_count    = r_count;
        o_overflow = r_ovf;
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : Processor data-memory responder. Decodes the memory-stage
//               address into a word-addressed RAM and a small MMIO block
//               (TXDATA, STATUS, ERRCNT) feeding a byte transmit FIFO.
//               Out-of-map accesses read as zero, are not written, and are
//               counted in a saturating 16-bit error counter.
//               Optional build macro DMEM_ACCESS_COUNT_EN adds RDCNT/WRCNT
//               registers counting in-map RAM reads and writes; without it
//               those addresses decode as out-of-map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int mbus       = 32,
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [mbus-1:0] addressData,
    input  logic [mbus-1:0] storeData,
    input  logic            MWE,
    input  logic            MRE,
    output logic [mbus-1:0] loadedData,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [c_errcnt_w-1:0] c_errcnt_max = '1;

    logic [mbus-1:0]         r_mem [DEPTH];
    logic [c_errcnt_w-1:0]   r_errcnt;

    region_e                 w_region;
    logic [AW-1:0]           w_ram_idx;
    logic                    w_access;
    logic                    w_push;
    logic                    w_ovf_clear;
    logic [7:0]              w_status;

    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_fifo_ovf;
    logic [c_stat_cnt_w-1:0] w_fifo_count;

`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0]             r_rdcnt;
    logic [31:0]             r_wrcnt;
`endif

    // Address decode: RAM occupies the low DEPTH*4 bytes, MMIO exact matches
    always_comb begin
        w_region = REGION_NONE;
        if (addressData[mbus-1:AW+2] == '0) begin
            w_region = REGION_RAM;
        end else if (addressData == mbus'(c_addr_txdata)) begin
            w_region = REGION_TXDATA;
        end else if (addressData == mbus'(c_addr_status)) begin
            w_region = REGION_STATUS;
        end else if (addressData == mbus'(c_addr_errcnt)) begin
            w_region = REGION_ERRCNT;
`ifdef DMEM_ACCESS_COUNT_EN
        end else if (addressData == mbus'(c_addr_rdcnt)) begin
            w_region = REGION_RDCNT;
        end else if (addressData == mbus'(c_addr_wrcnt)) begin
            w_region = REGION_WRCNT;
`endif
        end
    end

    // Byte-offset bits are dropped: every access is treated as word-aligned
    always_comb begin
        w_ram_idx   = addressData[AW+1:2];
        w_access    = MWE | MRE;
        w_push      = MWE & (w_region == REGION_TXDATA);
        w_ovf_clear = MRE & (w_region == REGION_STATUS);
        w_status    = pack_status(w_fifo_full, w_fifo_empty, w_fifo_ovf, w_fifo_count);
    end

    // Combinational read mux; RAM read sees the pre-edge word (read-before-write)
    always_comb begin
        loadedData = '0;
        if (MRE) begin
            case (w_region)
                REGION_RAM:    loadedData = r_mem[w_ram_idx];
                REGION_STATUS: loadedData = mbus'(w_status);
                REGION_ERRCNT: loadedData = mbus'(r_errcnt);
`ifdef DMEM_ACCESS_COUNT_EN
                REGION_RDCNT:  loadedData = mbus'(r_rdcnt);
                REGION_WRCNT:  loadedData = mbus'(r_wrcnt);
`endif
                default:       loadedData = '0;
            endcase
        end
    end

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (MWE && (w_region == REGION_RAM)) begin
            r_mem[w_ram_idx] <= storeData;
        end
    end

    // Saturating count of cycles with an out-of-map access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_errcnt <= '0;
        end else if (w_access && (w_region == REGION_NONE) && (r_errcnt != c_errcnt_max)) begin
            r_errcnt <= r_errcnt + c_errcnt_w'(1);
        end
    end

`ifdef DMEM_ACCESS_COUNT_EN
    // Wrapping counters of in-map RAM reads and writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdcnt <= '0;
            r_wrcnt <= '0;
        end else begin
            if (MRE && (w_region == REGION_RAM)) begin
                r_rdcnt <= r_rdcnt + 32'd1;
            end
            if (MWE && (w_region == REGION_RAM)) begin
                r_wrcnt <= r_wrcnt + 32'd1;
            end
        end
    end
`endif

    dmem_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (storeData[7:0]),
        .i_pop_ready (tx_ready),
        .i_ovf_clear (w_ovf_clear),
        .o_data      (tx_data),
        .o_valid     (tx_valid),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count),
        .o_overflow  (w_fifo_ovf)
    );

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter mbus, default 32: width of the data and address buses.
REQ-002 Parameter DEPTH, default 1024: number of RAM words; must be a power of two.
REQ-003 Parameter FIFO_DEPTH, default 8: number of TX FIFO entries; must be a power of two, at most 15.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 addressData  input  mbus  byte address from the processor memory stage.
REQ-007 storeData  input  mbus  write data.
REQ-008 MWE  input  1  write enable.
REQ-009 MRE  input  1  read enable.
REQ-010 loadedData  output  mbus  read data, combinational, valid in the same cycle as MRE.
REQ-011 tx_data  output  8  FIFO head byte.
REQ-012 tx_valid  output  1  FIFO non-empty.
REQ-013 tx_ready  input  1  consumer accepts the head byte.

Function
REQ-014 RAM region, addresses 0 to DEPTH*4-1, word index addressData[log2(DEPTH)+1:2]; addressData[1:0] ignored (no misalignment fault).
REQ-015 RAM write: when MWE=1 the word is written on the clock edge; when MRE=1, loadedData equals the current RAM word.
REQ-016 MWE=MRE=1 at the same address: loadedData shows the old word (read-before-write); the write commits at the edge.
REQ-017 MMIO at 0xFFFF_0000 TXDATA: a write pushes storeData[7:0]; a read returns 0.
REQ-018 MMIO at 0xFFFF_0004 STATUS, read-only: bit0 full, bit1 empty, bit2 sticky overflow, bits[7:4] FIFO count, all other bits 0.
REQ-019 A read of STATUS clears the overflow bit on that edge; overflow set and clear in the same cycle leaves the bit set.
REQ-020 MMIO at 0xFFFF_0008 ERRCNT, read-only: count of out-of-map accesses, 16-bit, saturating at 0xFFFF, zero-extended.
REQ-021 Out-of-map access (neither RAM nor a defined MMIO address): reads return 0, writes are ignored, and ERRCNT increments once per cycle in which MWE or MRE is asserted.
REQ-022 FIFO push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle; otherwise the byte is dropped and overflow is set.
REQ-023 Pop occurs when tx_valid and tx_ready are both 1; tx_data is stable while tx_valid=1 and tx_ready=0.
REQ-024 Push and pop in the same cycle: count is unchanged, order is preserved; with count=0, a push is not popped in the same cycle (tx_valid rises the next cycle).
REQ-025 Read/write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-026 MWE=MRE=0: no state changes except FIFO pops; loadedData=0.

Reset
REQ-027 While rst=0: FIFO count, pointers, overflow and ERRCNT are 0; tx_valid=0; tx_data=0.
REQ-028 RAM contents are not reset.
REQ-029 Reset asserted mid-transfer discards FIFO contents immediately, without waiting for a clock edge.

Configuration
REQ-030 Macro DMEM_ACCESS_COUNT_EN defined: MMIO at 0xFFFF_000C RDCNT and 0xFFFF_0010 WRCNT, 32-bit wrapping counters of in-map RAM reads and writes, reset to 0.
REQ-031 Macro DMEM_ACCESS_COUNT_EN undefined: no counter logic is present, and both addresses decode as out-of-map per REQ-021.

Structure
REQ-032 Package dmem_pkg holds the MMIO address constants, the STATUS bit-position constants and the region-decode enum (RAM, TXDATA, STATUS, ERRCNT, RDCNT, WRCNT, NONE).
REQ-033 One sub-module, dmem_tx_fifo, implements the FIFO (push, pop, full, empty, count, overflow); decode, RAM and counters are in the top level.

Verification
REQ-034 Write 0xDEADBEEF to 0x10, then MRE at 0x13 -> loadedData=0xDEADBEEF.
REQ-035 tx_ready=0, push 9 bytes 0x41..0x49 -> STATUS read = 0x0000_0085 (count 8, full, overflow); second STATUS read = 0x0000_0081; tx_ready=1 drains 0x41..0x48 in order, then tx_valid=0.
REQ-036 FIFO full with tx_ready=1, push 0x5A in the same cycle -> accepted, count stays 8, no overflow, 0x5A last out.
REQ-037 MRE at 0x8000_0000 three times, then MWE at 0x8000_0000 -> loadedData=0 on the reads, RAM unchanged, ERRCNT read = 4.
REQ-038 Push 3 bytes, assert rst=0 between clock edges -> tx_valid=0 immediately; after release STATUS=0x0000_0002.
REQ-039 With DMEM_ACCESS_COUNT_EN: 2 RAM reads and 1 RAM write -> RDCNT=2, WRCNT=1; without it, reading 0xFFFF_000C returns 0 and ERRCNT increments.
